// File: rtl/fm_ram_pkg.sv
// Shared widths, read-address limit, FSM encoding and grant encoding
// for the float16 accumulate-RAM controller.
package fm_ram_pkg;
    localparam int DATA_WIDTH       = 16;
    localparam int PARA_Y           = 2;
    localparam int READ_ADDR_WIDTH  = 4;
    localparam int WRITE_ADDR_WIDTH = 2;
    localparam int RD_ADDR_MAX      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_ADD1,
        ST_ADD2,
        ST_RD,
        ST_RD_RET
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;
endpackage

// File: rtl/fm_ram_ctrl_rr_arb2.sv
// Two-way round-robin grant between the write and read requesters.
// Latency: combinational, no state (last_grant is held by the caller).
// Backpressure: grants only while en is high; a lone requester always wins.
module rr_arb2
    import fm_ram_pkg::*;
(
    input  logic   en,
    input  logic   req_wr,
    input  logic   req_rd,
    input  grant_t last_grant,
    output logic   gnt_wr,
    output logic   gnt_rd
);
    assign gnt_wr = en && req_wr && (!req_rd || last_grant == GNT_RD);
    assign gnt_rd = en && req_rd && (!req_wr || last_grant == GNT_WR);
endmodule

// File: rtl/fm_ram_ctrl.sv
// Arbitrates write/accumulate and read requests onto a float16 accumulate RAM.
// Latency: write drives RAM 1 cycle after accept, read data valid 2 cycles after accept.
// Backpressure: wr_ready/rd_ready only in IDLE; overwrite 1/2, accumulate and read 1/3.
module fm_ram_ctrl #(
    parameter int DATA_WIDTH       = fm_ram_pkg::DATA_WIDTH,
    parameter int PARA_Y           = fm_ram_pkg::PARA_Y,
    parameter int READ_ADDR_WIDTH  = fm_ram_pkg::READ_ADDR_WIDTH,
    parameter int WRITE_ADDR_WIDTH = fm_ram_pkg::WRITE_ADDR_WIDTH,
    parameter int RD_ADDR_MAX      = fm_ram_pkg::RD_ADDR_MAX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic                         wr_accum,
    input  logic [WRITE_ADDR_WIDTH-1:0]  wr_addr,
    input  logic [PARA_Y*DATA_WIDTH-1:0] wr_data,
    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  logic [READ_ADDR_WIDTH-1:0]   rd_addr,
    output logic                         rd_data_valid,
    output logic [PARA_Y*DATA_WIDTH-1:0] rd_data,
    output logic                         rd_err,
    output logic                         busy,
    output logic                         ram_ena_wr,
    output logic                         ram_ena_add_write,
    output logic [WRITE_ADDR_WIDTH-1:0]  ram_addr_write,
    output logic [PARA_Y*DATA_WIDTH-1:0] ram_din,
    output logic [READ_ADDR_WIDTH-1:0]   ram_addr_read,
    input  logic                         ram_write_ready,
    input  logic [PARA_Y*DATA_WIDTH-1:0] ram_dout
);
    import fm_ram_pkg::*;

    state_t state;
    grant_t last_grant;
    logic   rst_pend;
    logic   gnt_wr;
    logic   gnt_rd;
    logic   rd_oob;
    logic   unused_write_ready;

    // The RAM's add-done flag is observed externally; the FSM never waits on it.
    assign unused_write_ready = ram_write_ready;

    rr_arb2 u_arb (
        .en         (state == ST_IDLE && !rst),
        .req_wr     (wr_valid),
        .req_rd     (rd_valid),
        .last_grant (last_grant),
        .gnt_wr     (gnt_wr),
        .gnt_rd     (gnt_rd)
    );

    assign wr_ready = gnt_wr;
    assign rd_ready = gnt_rd;
    assign busy     = (state != ST_IDLE);
    assign rd_oob   = rd_addr > READ_ADDR_WIDTH'(RD_ADDR_MAX);
    assign rd_data  = rd_data_valid ? ram_dout : '0;

    // Reset is deferred across ADD1 so the RAM always sees an even add phase.
    always_ff @(posedge clk) begin
        if ((rst && state != ST_ADD1) || (state == ST_ADD2 && rst_pend)) begin
            state             <= ST_IDLE;
            last_grant        <= GNT_RD;
            rst_pend          <= 1'b0;
            rd_data_valid     <= 1'b0;
            rd_err            <= 1'b0;
            ram_ena_wr        <= 1'b0;
            ram_ena_add_write <= 1'b0;
            ram_addr_write    <= '0;
            ram_din           <= '0;
            ram_addr_read     <= '0;
        end else begin
            rd_data_valid <= 1'b0;
            rd_err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_wr) begin
                        last_grant        <= GNT_WR;
                        ram_addr_write    <= wr_addr;
                        ram_din           <= wr_data;
                        ram_ena_wr        <= 1'b1;
                        ram_ena_add_write <= wr_accum;
                        state             <= wr_accum ? ST_ADD1 : ST_WR;
                    end else if (gnt_rd) begin
                        last_grant <= GNT_RD;
                        if (rd_oob) begin
                            rd_err <= 1'b1;
                        end else begin
                            ram_addr_read <= rd_addr;
                            state         <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    ram_ena_wr <= 1'b0;
                    state      <= ST_IDLE;
                end
                ST_ADD1: begin
                    rst_pend <= rst;
                    state    <= ST_ADD2;
                end
                ST_ADD2: begin
                    ram_ena_wr        <= 1'b0;
                    ram_ena_add_write <= 1'b0;
                    state             <= ST_IDLE;
                end
                ST_RD: begin
                    rd_data_valid <= 1'b1;
                    state         <= ST_RD_RET;
                end
                ST_RD_RET: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end
endmodule
